// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by the next-PC generator and the fetch_sequencer top.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Next-PC source selected by the sequencer each cycle.
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_ADV   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam int          PC_INC      = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: word-aligned redirect target, sequential
// advance by one instruction, or hold; also flags a misaligned target.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20
) (
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic [ADDRESS_WIDTH-1:0] redir_target,
    input  pc_sel_t                  sel,
    output logic [ADDRESS_WIDTH-1:0] next_pc,
    output logic                     target_misaligned
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_pc = pc;
        unique case (sel)
            PC_REDIR: next_pc = {redir_target[ADDRESS_WIDTH-1:2], 2'b00};
            // Wraps modulo 2^ADDRESS_WIDTH by construction of the adder width.
            PC_ADV:   next_pc = pc + ADDRESS_WIDTH'(PC_INC);
            default:  next_pc = pc;
        endcase
    end

    assign target_misaligned = |redir_target[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, reads the external combinational ROM and registers
// {Instr, PC} into the IF/ID register with a valid/ready handshake to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 20,
    parameter int                         DATA_WIDTH    = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDRESS_WIDTH-1:0]     PC,
    input  logic [4*DATA_WIDTH-1:0]      Instr,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [4*DATA_WIDTH-1:0]      id_instr,
    output logic [ADDRESS_WIDTH-1:0]     id_pc,
    input  logic                         redir_valid,
    input  logic [ADDRESS_WIDTH-1:0]     redir_target,
    output logic                         misalign_err,
    output logic                         halted
);

    localparam int IW = 4 * DATA_WIDTH;

    fetch_state_t             state, state_next;
    pc_sel_t                  pc_sel;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic                     target_misaligned;
    logic                     load;
    logic                     capture;
    logic                     flush;
    logic                     drop;

    fetch_pc_gen #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pc_gen (
        .pc               (PC),
        .redir_target     (redir_target),
        .sel              (pc_sel),
        .next_pc          (pc_next),
        .target_misaligned(target_misaligned)
    );

    // The IF/ID slot can take a new word when empty or being drained this cycle.
    assign load = ~id_valid | id_ready;

    always_comb begin
        state_next = state;
        pc_sel     = PC_HOLD;
        capture    = 1'b0;
        flush      = 1'b0;
        drop       = 1'b0;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                // Redirect wins over both capture and ECALL detection.
                if (redir_valid) begin
                    pc_sel = PC_REDIR;
                    flush  = 1'b1;
                end else if (load) begin
                    pc_sel  = PC_ADV;
                    capture = 1'b1;
                    if (Instr == IW'(INSTR_ECALL)) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: drop = id_valid & id_ready;
            default: state_next = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            PC    <= RESET_PC;
        end else begin
            state <= state_next;
            PC    <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (capture) begin
            id_valid <= 1'b1;
            id_instr <= Instr;
            id_pc    <= PC;
        end else if (flush || drop) begin
            id_valid <= 1'b0;
        end
    end

    assign misalign_err = (state == RUN) & redir_valid & target_misaligned;
    assign halted       = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a ROM model feeds Instr, a scoreboard
// queue holds expected {pc, instr} per accepted IF/ID handshake.
module tb_fetch_sequencer;

    localparam int AW = 20;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] PC;
    logic [31:0]   Instr;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc;
    logic          redir_valid = 1'b0;
    logic [AW-1:0] redir_target = '0;
    logic          misalign_err;
    logic          halted;
    logic          ecall_en = 1'b0;

    int  vectors = 0;
    int  miscompares = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    // ROM: tagged address everywhere, ECALL at 'h10 once enabled.
    assign Instr = (ecall_en && PC == 20'h00010) ? 32'h0000_0073 : {12'hA5C, PC};

    fetch_sequencer #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .RESET_PC     ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .Instr       (Instr),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .misalign_err(misalign_err),
        .halted      (halted)
    );

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a, input logic e);
        return (e && a == 20'h00010) ? 32'h0000_0073 : {12'hA5C, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a);
        sb_t e;
        e.pc    = a;
        e.instr = rom_word(a, ecall_en);
        sb.push_back(e);
    endtask

    // Called at a negedge with inputs already driven; scores the handshake
    // that completes at the coming posedge, then advances to the next negedge.
    task automatic cyc();
        sb_t e;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_id_pc", 64'(id_pc), 64'(e.pc));
                check("sb_id_instr", 64'(id_instr), 64'(e.instr));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", 64'(PC), 64'h0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_instr", 64'(id_instr), 64'h0);
        check("rst_id_pc", 64'(id_pc), 64'h0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);

        // 1: stream from reset, id_valid on 2nd edge after release
        rst = 1'b1;
        id_ready = 1'b1;
        push(20'h0); push(20'h4); push(20'h8); push(20'hC);
        cyc();
        check("boot_no_capture", 64'(id_valid), 64'd0);
        cyc();
        check("first_valid", 64'(id_valid), 64'd1);
        check("first_id_pc", 64'(id_pc), 64'h0);
        check("first_pc", 64'(PC), 64'h4);
        cyc();
        check("seq_id_pc4", 64'(id_pc), 64'h4);
        cyc();
        check("seq_id_pc8", 64'(id_pc), 64'h8);

        // 2: stall three cycles at id_pc=8
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_id_pc", 64'(id_pc), 64'h8);
            check("stall_id_instr", 64'(id_instr), 64'(rom_word(20'h8, 1'b0)));
            check("stall_pc", 64'(PC), 64'hC);
            check("stall_valid", 64'(id_valid), 64'd1);
        end
        id_ready = 1'b1;
        cyc();
        check("resume_id_pc", 64'(id_pc), 64'hC);

        // 3: aligned redirect flushes and refetches at target
        redir_valid = 1'b1;
        redir_target = 20'h40;
        check("aligned_no_misalign", 64'(misalign_err), 64'd0);
        cyc();
        redir_valid = 1'b0;
        check("redir_flush", 64'(id_valid), 64'd0);
        check("redir_pc", 64'(PC), 64'h40);
        push(20'h40);
        cyc();
        check("redir_id_pc", 64'(id_pc), 64'h40);

        // 4: misaligned redirect pulses misalign_err and aligns PC
        redir_valid = 1'b1;
        redir_target = 20'h42;
        #1;
        check("misalign_pulse", 64'(misalign_err), 64'd1);
        cyc();
        redir_valid = 1'b0;
        #1;
        check("misalign_clear", 64'(misalign_err), 64'd0);
        check("misalign_pc", 64'(PC), 64'h40);
        check("misalign_flush", 64'(id_valid), 64'd0);
        push(20'h40);
        cyc();

        // 6a: PC wraps from 2^AW-4 to 0
        redir_valid = 1'b1;
        redir_target = 20'hFFFFC;
        cyc();
        redir_valid = 1'b0;
        push(20'hFFFFC); push(20'h0);
        cyc();
        check("wrap_id_pc_top", 64'(id_pc), 64'hFFFFC);
        check("wrap_pc_zero", 64'(PC), 64'h0);
        cyc();
        check("wrap_id_pc_zero", 64'(id_pc), 64'h0);

        // 5: ECALL at 'h10 halts with PC frozen at 'h14
        ecall_en = 1'b1;
        redir_valid = 1'b1;
        redir_target = 20'h8;
        cyc();
        redir_valid = 1'b0;
        push(20'h8); push(20'hC); push(20'h10);
        cyc();
        cyc();
        check("pre_ecall_halted", 64'(halted), 64'd0);
        cyc();
        check("ecall_instr", 64'(id_instr), 64'h73);
        check("ecall_id_pc", 64'(id_pc), 64'h10);
        check("ecall_halted", 64'(halted), 64'd1);
        check("ecall_pc", 64'(PC), 64'h14);
        id_ready = 1'b0;
        cyc();
        check("halt_hold_valid", 64'(id_valid), 64'd1);
        check("halt_hold_pc", 64'(PC), 64'h14);
        id_ready = 1'b1;
        redir_valid = 1'b1;
        redir_target = 20'h42;
        #1;
        check("halt_no_misalign", 64'(misalign_err), 64'd0);
        cyc();
        redir_valid = 1'b0;
        check("halt_drained", 64'(id_valid), 64'd0);
        check("halt_redir_ignored", 64'(PC), 64'h14);
        cyc();
        check("halt_still_pc", 64'(PC), 64'h14);
        check("halt_still_halted", 64'(halted), 64'd1);
        check("halt_still_empty", 64'(id_valid), 64'd0);

        // 6b: reset asserted mid-stall returns everything at once
        rst = 1'b0;
        ecall_en = 1'b0;
        id_ready = 1'b0;
        #1;
        check("rerst_halted", 64'(halted), 64'd0);
        cyc();
        rst = 1'b1;
        id_ready = 1'b1;
        push(20'h0); push(20'h4);
        cyc();
        cyc();
        cyc();
        cyc();
        id_ready = 1'b0;
        cyc();
        check("prestall_id_pc", 64'(id_pc), 64'h8);
        check("prestall_pc", 64'(PC), 64'hC);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_pc", 64'(PC), 64'h0);
        check("midrst_id_valid", 64'(id_valid), 64'd0);
        check("midrst_id_instr", 64'(id_instr), 64'h0);
        check("midrst_id_pc", 64'(id_pc), 64'h0);
        check("midrst_halted", 64'(halted), 64'd0);
        check("midrst_misalign", 64'(misalign_err), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
